// File: rtl/nf10_axi_lite_regs.sv
// AXI4-Lite slave register file: C_NUM_RW read/write registers followed by
// C_NUM_RO read-only registers sampled from user logic.
module nf10_axi_lite_regs #(
    parameter logic [31:0] C_BASEADDR  = 32'h7d400000,
    parameter logic [31:0] C_HIGHADDR  = 32'h7d40ffff,
    parameter int          C_NUM_RW    = 4,
    parameter int          C_NUM_RO    = 4,
    parameter logic [31:0] C_RESET_VAL = 32'h0
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESET,
    input  logic [31:0]             S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [31:0]             S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [32*C_NUM_RW-1:0]  rw_regs,
    output logic [C_NUM_RW-1:0]     wr_pulse,
    input  logic [32*C_NUM_RO-1:0]  ro_regs
);

    localparam logic [31:0] L_NUM_RW = 32'(C_NUM_RW);
    localparam logic [31:0] L_TOTAL  = 32'(C_NUM_RW + C_NUM_RO);

    function automatic logic [31:0] addr_idx(input logic [31:0] addr);
        return (addr - C_BASEADDR) >> 2;
    endfunction

    function automatic logic [1:0] decode_resp(input logic [31:0] addr, input logic is_wr);
        logic [1:0] resp;
        if ((addr < C_BASEADDR) || (addr > C_HIGHADDR)) begin
            resp = 2'b11;
        end else if (addr_idx(addr) >= L_TOTAL) begin
            resp = 2'b10;
        end else if (is_wr && (addr_idx(addr) >= L_NUM_RW)) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
        end
        return resp;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    logic                r_aw_held;
    logic [31:0]         r_aw_addr;
    logic                r_w_held;
    logic [31:0]         r_w_data;
    logic [3:0]          r_w_strb;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_rvalid;
    logic [1:0]          r_rresp;
    logic [31:0]         r_rdata;
    logic [31:0]         r_rw [C_NUM_RW];
    logic [C_NUM_RW-1:0] r_wr_pulse;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_commit;
    logic [31:0] w_wr_addr;
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_strb;
    logic [31:0] w_wr_idx;
    logic [1:0]  w_wr_resp;
    logic [31:0] w_rd_idx;
    logic [1:0]  w_rd_resp;
    logic [31:0] w_rd_val;

    assign S_AXI_AWREADY = !S_AXI_ARESET && !r_aw_held && !r_bvalid;
    assign S_AXI_WREADY  = !S_AXI_ARESET && !r_w_held && !r_bvalid;
    assign S_AXI_ARREADY = !S_AXI_ARESET && !r_rvalid;

    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A held beat takes priority; otherwise the beat handshaking this cycle is used.
    assign w_wr_addr = r_aw_held ? r_aw_addr : S_AXI_AWADDR;
    assign w_wr_data = r_w_held ? r_w_data : S_AXI_WDATA;
    assign w_wr_strb = r_w_held ? r_w_strb : S_AXI_WSTRB;
    assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;
    assign w_wr_idx  = addr_idx(w_wr_addr);
    assign w_wr_resp = decode_resp(w_wr_addr, 1'b1);

    assign w_rd_idx  = addr_idx(S_AXI_ARADDR);
    assign w_rd_resp = decode_resp(S_AXI_ARADDR, 1'b0);

    // Read data mux over RW registers and RO inputs
    always_comb begin
        w_rd_val = 32'h0;
        for (int i = 0; i < C_NUM_RW; i++) begin
            w_rd_val = (w_rd_idx == 32'(i)) ? r_rw[i] : w_rd_val;
        end
        for (int j = 0; j < C_NUM_RO; j++) begin
            w_rd_val = (w_rd_idx == 32'(C_NUM_RW + j)) ? ro_regs[32*j +: 32] : w_rd_val;
        end
    end

    // Write channel: beat holding, commit, register update and response
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_aw_held  <= 1'b0;
            r_aw_addr  <= 32'h0;
            r_w_held   <= 1'b0;
            r_w_data   <= 32'h0;
            r_w_strb   <= 4'h0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_wr_pulse <= '0;
            for (int i = 0; i < C_NUM_RW; i++) begin
                r_rw[i] <= C_RESET_VAL;
            end
        end else begin
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_resp;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_addr <= S_AXI_AWADDR;
                end else begin
                    r_aw_held <= r_aw_held;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= S_AXI_WDATA;
                    r_w_strb <= S_AXI_WSTRB;
                end else begin
                    r_w_held <= r_w_held;
                end
                if (r_bvalid && S_AXI_BREADY) begin
                    r_bvalid <= 1'b0;
                end else begin
                    r_bvalid <= r_bvalid;
                end
            end
            for (int i = 0; i < C_NUM_RW; i++) begin
                if (w_commit && (w_wr_resp == 2'b00) && (w_wr_idx == 32'(i))) begin
                    r_rw[i]       <= merge_bytes(r_rw[i], w_wr_data, w_wr_strb);
                    r_wr_pulse[i] <= 1'b1;
                end else begin
                    r_wr_pulse[i] <= 1'b0;
                end
            end
        end
    end

    // Read channel: capture on AR handshake, hold until RREADY
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rvalid <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= 32'h0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_resp;
            r_rdata  <= (w_rd_resp == 2'b00) ? w_rd_val : 32'h0;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= r_rvalid;
        end
    end

    for (genvar g = 0; g < C_NUM_RW; g++) begin : g_rw_out
        assign rw_regs[32*g +: 32] = r_rw[g];
    end

    assign wr_pulse     = r_wr_pulse;
    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RRESP  = r_rresp;
    assign S_AXI_RDATA  = r_rdata;

endmodule

// File: tb/tb_nf10_axi_lite_regs.sv
// Bench for nf10_axi_lite_regs: directed scenarios plus random transactions
// checked against an array-based model of the register map.
module tb_nf10_axi_lite_regs;

    localparam logic [31:0] BASE = 32'h7d400000;
    localparam logic [31:0] HIGH = 32'h7d40ffff;

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    logic [31:0]  awaddr = 32'h0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = 32'h0;
    logic [3:0]   wstrb = 4'h0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [31:0]  araddr = 32'h0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [127:0] rw_regs;
    logic [3:0]   wr_pulse;
    logic [127:0] ro_regs = 128'h0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model_rw [4];

    nf10_axi_lite_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .rw_regs(rw_regs), .wr_pulse(wr_pulse), .ro_regs(ro_regs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_resp(input logic [31:0] addr, input bit is_wr);
        longint unsigned idx;
        if (addr < BASE || addr > HIGH) return 2'b11;
        idx = longint'(addr - BASE) / 4;
        if (idx >= 8) return 2'b10;
        if (is_wr && idx >= 4) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx;
        if (model_resp(addr, 1'b0) != 2'b00) return 32'h0;
        idx = int'((addr - BASE) / 4);
        if (idx < 4) return model_rw[idx];
        return ro_regs[32*(idx-4) +: 32];
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) check(tag, rw_regs[32*i +: 32], model_rw[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        areset = 1'b1;
        #1;
        check("rst_awready", {31'h0, awready}, 32'h0);
        check("rst_arready", {31'h0, arready}, 32'h0);
        tick();
        areset = 1'b0;
        for (int i = 0; i < 4; i++) model_rw[i] = 32'h0;
        #1;
        check("rst_bvalid", {31'h0, bvalid}, 32'h0);
        check("rst_rvalid", {31'h0, rvalid}, 32'h0);
        check("rst_wr_pulse", {28'h0, wr_pulse}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check_regs("rst_rw");
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit release_b);
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        int guard = 0;
        logic [1:0] exp_resp;
        logic [3:0] exp_pulse = 4'h0;
        int idx;
        exp_resp = model_resp(addr, 1'b1);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && guard < 20) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            tick();
            guard++;
            if (aw_go) begin aw_done = 1; awvalid = 1'b0; end
            if (w_go)  begin w_done = 1;  wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_accept", {30'h0, aw_done, w_done}, 32'h3);
        if (exp_resp == 2'b00) begin
            idx = int'((addr - BASE) / 4);
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_rw[idx][8*b +: 8] = data[8*b +: 8];
            exp_pulse[idx] = 1'b1;
        end
        check("wr_bvalid", {31'h0, bvalid}, 32'h1);
        check("wr_bresp", {30'h0, bresp}, {30'h0, exp_resp});
        check("wr_pulse", {28'h0, wr_pulse}, {28'h0, exp_pulse});
        check_regs("wr_regs");
        if (release_b) begin
            bready = 1'b1;
            tick();
            bready = 1'b0;
            check("wr_bvalid_clr", {31'h0, bvalid}, 32'h0);
            check("wr_pulse_clr", {28'h0, wr_pulse}, 32'h0);
        end
    endtask

    task automatic read_txn(input logic [31:0] addr, input int hold);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bit go = 0;
        int guard = 0;
        exp_data = model_read(addr);
        exp_resp = model_resp(addr, 1'b0);
        araddr = addr; arvalid = 1'b1;
        while (!go && guard < 20) begin
            go = arready;
            tick();
            guard++;
        end
        arvalid = 1'b0;
        check("rd_accept", {31'h0, go}, 32'h1);
        check("rd_rvalid", {31'h0, rvalid}, 32'h1);
        check("rd_rdata", rdata, exp_data);
        check("rd_rresp", {30'h0, rresp}, {30'h0, exp_resp});
        for (int k = 0; k < hold; k++) begin
            tick();
            check("rd_hold_rvalid", {31'h0, rvalid}, 32'h1);
            check("rd_hold_rdata", rdata, exp_data);
            check("rd_hold_arready", {31'h0, arready}, 32'h0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rd_rvalid_clr", {31'h0, rvalid}, 32'h0);
        check("rd_arready_back", {31'h0, arready}, 32'h1);
    endtask

    initial begin
        logic [31:0] a;
        int sel;
        for (int i = 0; i < 4; i++) model_rw[i] = 32'h0;
        tick();
        do_reset();

        // Same-cycle AW+W to reg1
        write_txn(32'h7d400004, 32'hA5A5A5A5, 4'hF, 1'b1);

        // Data three cycles ahead of address, partial strobes
        write_txn(32'h7d400000, 32'hFFFFFFFF, 4'hF, 1'b1);
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        check("early_w_wready", {31'h0, wready}, 32'h1);
        tick();
        wvalid = 1'b0;
        check("early_w_held", {31'h0, wready}, 32'h0);
        tick();
        tick();
        check("early_w_nob", {31'h0, bvalid}, 32'h0);
        check("early_w_still_held", {31'h0, wready}, 32'h0);
        awaddr = 32'h7d400000; awvalid = 1'b1;
        check("early_w_awready", {31'h0, awready}, 32'h1);
        tick();
        awvalid = 1'b0;
        model_rw[0] = 32'hFF22FF44;
        check("early_w_bvalid", {31'h0, bvalid}, 32'h1);
        check("early_w_pulse", {28'h0, wr_pulse}, 32'h1);
        check_regs("early_w_regs");
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("early_w_wready_back", {31'h0, wready}, 32'h1);

        // RO read with back-pressure
        ro_regs[63:32] = 32'hCAFEF00D;
        read_txn(32'h7d400014, 4);

        // Error responses
        read_txn(32'h7d400100, 0);
        write_txn(32'h7d400100, 32'h87654321, 4'hF, 1'b1);
        read_txn(32'h7d410000, 0);
        read_txn(32'h7d3ffffc, 0);
        write_txn(32'h7d400010, 32'h87654321, 4'hF, 1'b1);
        write_txn(32'h7d400008, 32'h0BADF00D, 4'h0, 1'b1);

        // Read racing a write commit on the same register
        write_txn(32'h7d400008, 32'h0, 4'hF, 1'b1);
        awaddr = 32'h7d400008; wdata = 32'h12345678; wstrb = 4'hF;
        araddr = 32'h7d400008;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model_rw[2] = 32'h12345678;
        check("race_rvalid", {31'h0, rvalid}, 32'h1);
        check("race_rdata_old", rdata, 32'h0);
        check("race_bvalid", {31'h0, bvalid}, 32'h1);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        read_txn(32'h7d400008, 0);

        // Reset with a response pending, then with a held data beat
        write_txn(32'h7d40000c, 32'h13579BDF, 4'hF, 1'b0);
        do_reset();
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("held_w_before_rst", {31'h0, wready}, 32'h0);
        do_reset();
        check("held_w_discarded", {31'h0, wready}, 32'h1);
        write_txn(32'h7d400004, 32'h55AA1234, 4'hF, 1'b1);

        // Random traffic
        for (int it = 0; it < 80; it++) begin
            sel = $urandom_range(0, 11);
            if (sel < 10) a = BASE + 32'(sel) * 32'd4 + 32'($urandom_range(0, 3));
            else if (sel == 10) a = HIGH + 32'd1 + 32'($urandom_range(0, 64));
            else a = BASE - 32'd1 - 32'($urandom_range(0, 64));
            if ($urandom_range(0, 3) == 0) ro_regs = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 0) write_txn(a, $urandom, 4'($urandom), 1'b1);
            else read_txn(a, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nf10_axi_lite_regs.md
Name: nf10_axi_lite_regs

Overview:
- AXI4-Lite slave register file. It is the responder for the DMA block's M_AXI_LITE master port.
- Decodes the address window C_BASEADDR..C_HIGHADDR into C_NUM_RW read/write registers followed by C_NUM_RO read-only registers.
- Exposes the RW values and per-register write strobes to user logic and samples the RO values from user logic.
- Used by every datapath module that needs host-visible control or status registers.

Parameters:
C_BASEADDR, 32'h7d400000, first byte address of the window
C_HIGHADDR, 32'h7d40ffff, last byte address of the window
C_NUM_RW, 4, number of RW registers (indices 0..C_NUM_RW-1)
C_NUM_RO, 4, number of RO registers (indices C_NUM_RW..C_NUM_RW+C_NUM_RO-1); C_NUM_RW+C_NUM_RO <= 256
C_RESET_VAL, 32'h0, reset value of every RW register

Ports:
S_AXI_ACLK  in  1  single clock for all logic
S_AXI_ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  32  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  32  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
rw_regs  out  32*C_NUM_RW  RW register values; register i is at [32i+31:32i]
wr_pulse  out  C_NUM_RW  one-cycle strobe per RW register written
ro_regs  in  32*C_NUM_RO  RO values; RO register j is at [32j+31:32j]

Behaviour:
- Reset (S_AXI_ARESET high at a clock edge):
  - BVALID, RVALID, wr_pulse = 0; BRESP, RRESP = 2'b00; RDATA = 0; all RW registers = C_RESET_VAL.
  - AW and W holding flags are cleared; any pending transaction is discarded without a response.
  - AWREADY, WREADY, ARREADY are forced 0 while reset is high.
- Address decode:
  - Addresses outside [C_BASEADDR, C_HIGHADDR] -> DECERR (2'b11).
  - Inside the window: idx = (addr - C_BASEADDR) >> 2; addr[1:0] is ignored.
  - idx >= C_NUM_RW+C_NUM_RO -> SLVERR (2'b10).
  - Otherwise -> OKAY (2'b00).
  - Writes to RO indices -> SLVERR, no effect.
- Write channel:
  - AWREADY = !aw_held & !BVALID; WREADY = !w_held & !BVALID.
  - AW and W are accepted independently, in any order; an accepted beat is latched into aw_held / w_held.
  - Commit occurs at the edge where an address (held or handshaking) and data (held or handshaking) are both present and BVALID = 0.
  - At commit: byte lanes with WSTRB=1 are updated (only when the response is OKAY); BVALID <= 1; BRESP <= decoded response; both held flags are cleared.
  - Latency: AW+W handshaking at edge T -> register value, BVALID and wr_pulse[idx] are visible in cycle T+1.
  - wr_pulse is asserted for OKAY writes even when WSTRB = 0; it lasts exactly one cycle.
  - BVALID is held until the edge where BREADY = 1. No new AW/W is accepted while BVALID = 1. Minimum write spacing is 2 cycles.
- Read channel:
  - ARREADY = !RVALID.
  - On the AR handshake edge: RDATA <= register or ro_regs value (0 on error), RRESP <= decoded response, RVALID <= 1.
  - RDATA and RRESP stay stable until the edge where RREADY = 1, at which point RVALID <= 0.
  - ARREADY returns to 1 in the following cycle.
- Simultaneous events:
  - A read handshake at the same edge as a write commit to the same register returns the pre-write value.
  - Read and write channels never stall each other.
- The block never asserts BVALID or RVALID without a prior accepted request.

Test Plan:
1. Reset, then AW=0x7d400004 and W=0xA5A5A5A5 with WSTRB=4'hF in the same cycle, BREADY=1 -> BVALID=1 with BRESP=00 next cycle; rw_regs[63:32]=0xA5A5A5A5; wr_pulse=4'b0010 for exactly one cycle.
2. reg0=0xFFFFFFFF; drive W=0x11223344, WSTRB=4'b0101 three cycles before AW=0x7d400000 -> WREADY low after W is accepted; BVALID one cycle after the AW handshake; reg0=0xFF22FF44.
3. ro_regs[63:32]=0xCAFEF00D; read 0x7d400014 with RREADY low for 4 cycles -> RVALID held, RDATA=0xCAFEF00D stable, ARREADY=0 until RREADY=1, then ARREADY=1.
4. Read 0x7d400100 -> RRESP=10, RDATA=0. Write 0x7d400100 -> BRESP=10, no register change, wr_pulse=0. Read 0x7d410000 -> RRESP=11. Write to RO index 4 -> BRESP=10.
5. reg2=0; a write of 0x12345678 to 0x7d400008 commits on the same edge as an AR to 0x7d400008 -> RDATA=0x00000000; a following read returns 0x12345678.
6. Hold W with no AW and keep BVALID pending on a separate write, then assert S_AXI_ARESET for 1 cycle -> BVALID=0, rw_regs=0, held W discarded; the next full write to reg1 completes with the correct data.
